// File: rtl/reset_stretch_sequencer.sv
// Reset release synchronizer and stretcher driving the downstream clock/reset broadcast node.
// Define RESET_SEQ_SW_RESET_EN to enable the software-requested domain reset (SWRST) path.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ASSERT  0  | held in reset, waiting for synchronized reset release
// STRETCH 1  | release seen, output reset held for STRETCH_CYCLES edges
// RUN     2  | output reset released, domain running
// SWRST   3  | software-requested reset, held for STRETCH_CYCLES edges
module reset_stretch_sequencer #(
    parameter int SYNC_STAGES    = 3,
    parameter int STRETCH_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    output logic       auto_out_clock,
    output logic       auto_out_reset,
    input  logic       sw_reset_req,
    output logic       sw_reset_ack,
    output logic [1:0] seq_state
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RUN     = 2'd2,
        ST_SWRST   = 2'd3
    } state_e;

    localparam logic [7:0] CNT_TERM = 8'(STRETCH_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_ok;
    logic                   sync_ok_next;
    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   rst_out_q, rst_out_d;
    logic                   ack_q, ack_d;

    assign auto_out_clock = clock;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Leaving ASSERT on the edge that loads sync_ok makes the output reset
    // fall exactly SYNC_STAGES+STRETCH_CYCLES edges after release.
    assign sync_ok      = sync_q[SYNC_STAGES-1];
    assign sync_ok_next = sync_q[SYNC_STAGES-2];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= 8'd0;
            rst_out_q <= 1'b1;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ASSERT: begin
                cnt_d = 8'd0;
                if (sync_ok_next || sync_ok) begin
                    state_d = ST_STRETCH;
                end
            end
            ST_STRETCH, ST_SWRST: begin
                if (cnt_q == CNT_TERM) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                cnt_d = 8'd0;
`ifdef RESET_SEQ_SW_RESET_EN
                if (sw_reset_req) begin
                    state_d = ST_SWRST;
                end
`endif
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output flops are loaded from the next state so they change on the same edge as the state.
    always_comb begin
        rst_out_d = (state_d != ST_RUN);
        ack_d     = (state_q == ST_SWRST) && (state_d == ST_RUN);
    end

    assign auto_out_reset = rst_out_q;
    assign seq_state      = state_q;

`ifdef RESET_SEQ_SW_RESET_EN
    assign sw_reset_ack = ack_q;
`else
    logic sw_path_unused;
    assign sw_path_unused = sw_reset_req | ack_q;
    assign sw_reset_ack   = 1'b0;
`endif

endmodule

// File: tb/tb_reset_stretch_sequencer.sv
// Randomized bench for reset_stretch_sequencer: two instances (3/16 and 2/1) against
// an edge-counting reference model; follows RESET_SEQ_SW_RESET_EN if defined.
module tb_reset_stretch_sequencer;

`ifdef RESET_SEQ_SW_RESET_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       sw_req;
    logic       aclk_a, arst_a, ack_a;
    logic       aclk_b, arst_b, ack_b;
    logic [1:0] st_a, st_b;

    always #5 clock = ~clock;

    reset_stretch_sequencer #(.SYNC_STAGES(3), .STRETCH_CYCLES(16)) dut_a (
        .clock          (clock),
        .reset          (reset),
        .auto_out_clock (aclk_a),
        .auto_out_reset (arst_a),
        .sw_reset_req   (sw_req),
        .sw_reset_ack   (ack_a),
        .seq_state      (st_a)
    );

    reset_stretch_sequencer #(.SYNC_STAGES(2), .STRETCH_CYCLES(1)) dut_b (
        .clock          (clock),
        .reset          (reset),
        .auto_out_clock (aclk_b),
        .auto_out_reset (arst_b),
        .sw_reset_req   (sw_req),
        .sw_reset_ack   (ack_b),
        .seq_state      (st_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: edges since release decide the boot phase; a remaining-cycle
    // count tracks an active software reset.
    int n_sync[2]    = '{3, 2};
    int n_stretch[2] = '{16, 1};
    int edges[2];
    int sw_left[2];
    bit m_ack[2];
    bit in_rst;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            edges[k]   = 0;
            sw_left[k] = 0;
            m_ack[k]   = 1'b0;
        end
    endtask

    task automatic model_edge(input bit req);
        for (int k = 0; k < 2; k++) begin
            bit was_run;
            was_run  = (edges[k] >= n_sync[k] + n_stretch[k]) && (sw_left[k] == 0);
            m_ack[k] = 1'b0;
            if (!in_rst) begin
                if (SW_EN && sw_left[k] > 0) begin
                    sw_left[k]--;
                    if (sw_left[k] == 0) m_ack[k] = 1'b1;
                end else if (SW_EN && was_run && req) begin
                    sw_left[k] = n_stretch[k];
                end
                if (edges[k] < 100000) edges[k]++;
            end
        end
    endtask

    function automatic int exp_state(input int k);
        if (edges[k] < n_sync[k]) return 0;
        if (edges[k] < n_sync[k] + n_stretch[k]) return 1;
        return (sw_left[k] > 0) ? 3 : 2;
    endfunction

    function automatic int exp_rst(input int k);
        return ((edges[k] < n_sync[k] + n_stretch[k]) || (sw_left[k] > 0)) ? 1 : 0;
    endfunction

    task automatic check_all(input string ph);
        check_eq($sformatf("%s a.rst", ph), int'(arst_a), exp_rst(0));
        check_eq($sformatf("%s a.state", ph), int'(st_a), exp_state(0));
        check_eq($sformatf("%s a.ack", ph), int'(ack_a), int'(m_ack[0]));
        check_eq($sformatf("%s b.rst", ph), int'(arst_b), exp_rst(1));
        check_eq($sformatf("%s b.state", ph), int'(st_b), exp_state(1));
        check_eq($sformatf("%s b.ack", ph), int'(ack_b), int'(m_ack[1]));
        check_eq($sformatf("%s a.clk", ph), int'(aclk_a), int'(clock));
        check_eq($sformatf("%s b.clk", ph), int'(aclk_b), int'(clock));
    endtask

    task automatic cycle(input bit req, input string ph);
        sw_req = req;
        @(posedge clock);
        model_edge(req);
        @(negedge clock);
        check_all(ph);
    endtask

    // Async abort in the middle of a low clock phase, then re-release between edges.
    task automatic abort_and_release(input string ph);
        #2;
        reset  = 1'b0;
        in_rst = 1'b1;
        model_reset();
        #1;
        check_all($sformatf("%s abort", ph));
        cycle(1'b0, $sformatf("%s hold", ph));
        cycle(1'b0, $sformatf("%s hold", ph));
        reset  = 1'b1;
        in_rst = 1'b0;
    endtask

    initial begin
        bit req;
        reset  = 1'b0;
        sw_req = 1'b0;
        in_rst = 1'b1;
        model_reset();
        @(negedge clock);
        check_all("por");
        cycle(1'b0, "por");
        cycle(1'b0, "por");
        reset  = 1'b1;
        in_rst = 1'b0;

        for (int i = 0; i < 25; i++) cycle(1'b0, "boot");

        req = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) req = ~req;
            cycle(req, "rand");
        end

        // Walk into SWRST and abort at counter 7 of the long instance.
        for (int i = 0; i < 100; i++) begin
            if (SW_EN && sw_left[0] == n_stretch[0] - 7) break;
            cycle(1'b1, "toabort");
        end
        if (SW_EN) check_eq("abort_reached", sw_left[0], n_stretch[0] - 7);
        abort_and_release("mid_swrst");

        // Request held from release; dropped once the long instance acks.
        req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cycle(req, "early");
            if (m_ack[0]) req = 1'b0;
        end

        for (int ep = 0; ep < 4; ep++) begin
            int len;
            len = $urandom_range(5, 80);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) == 0) req = ~req;
                cycle(req, $sformatf("ep%0d", ep));
            end
            abort_and_release($sformatf("ep%0d", ep));
            for (int i = 0; i < 25; i++) cycle(1'b0, $sformatf("ep%0d boot", ep));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reset_stretch_sequencer.md
RESET_STRETCH_SEQUENCER -- requirements
Module: reset_stretch_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 3, number of reset-release synchronizer flops (legal range 2..4).
REQ-002 SHALL have parameter STRETCH_CYCLES, default 16, number of cycles the output reset is held after synchronized release (legal range 1..255).
REQ-003 SHALL have port clock, input, 1, the single block clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port auto_out_clock, output, 1, clock forwarded to the downstream clock broadcast node.
REQ-006 SHALL have port auto_out_reset, output, 1, active-high reset, synchronous to clock, forwarded to the downstream clock broadcast node.
REQ-007 SHALL have port sw_reset_req, input, 1, level request for a software-initiated domain reset.
REQ-008 SHALL have port sw_reset_ack, output, 1, single-cycle completion pulse for sw_reset_req.
REQ-009 SHALL have port seq_state, output, 2, current state encoding: ASSERT=0, STRETCH=1, RUN=2, SWRST=3.

Function
REQ-010 SHALL drive auto_out_clock combinationally equal to clock, with no gating or logic.
REQ-011 SHALL shift a constant 1 through a SYNC_STAGES-deep flop chain cleared by reset; the last stage is sync_ok.
REQ-012 SHALL implement states ASSERT, STRETCH, RUN and SWRST, held in a registered state and counter.
REQ-013 ASSERT: auto_out_reset=1, counter=0; transition to STRETCH on the edge where sync_ok is 1.
REQ-014 STRETCH: auto_out_reset=1; counter increments each edge; on counter==STRETCH_CYCLES-1, transition to RUN and clear counter.
REQ-015 auto_out_reset SHALL be registered and SHALL fall on exactly the (SYNC_STAGES+STRETCH_CYCLES)-th rising edge after reset goes high.
REQ-016 RUN: auto_out_reset=0; sw_reset_req=1 sampled on an edge moves to SWRST, and auto_out_reset is 1 after that same edge.
REQ-017 SWRST: auto_out_reset=1; counter increments; on counter==STRETCH_CYCLES-1, return to RUN, clear counter, and assert sw_reset_ack for exactly one cycle, coincident with auto_out_reset returning to 0.
REQ-018 sw_reset_req in ASSERT or STRETCH SHALL NOT be lost; it is acted on at the first RUN edge if still high.
REQ-019 Requester SHALL drop sw_reset_req in the cycle ack is seen; if req is still high in the cycle after ack, a new SWRST sequence starts.
REQ-020 Counter width SHALL be 8 bits; the counter SHALL NOT wrap, because the terminal compare always exits first.
REQ-021 seq_state SHALL reflect the registered state with zero added latency.

Reset
REQ-022 Reset low SHALL asynchronously force: sync chain=0, state=ASSERT, counter=0, auto_out_reset=1, sw_reset_ack=0, seq_state=0.
REQ-023 Reset asserted in any state, including mid-STRETCH or mid-SWRST, SHALL abort immediately; no ack is issued for an aborted SWRST.
REQ-024 Reset deassertion SHALL be synchronized only through the REQ-011 chain; no other flop uses unsynchronized release for sequencing decisions.

Configuration
REQ-025 Macro RESET_SEQ_SW_RESET_EN SHALL gate the software reset path.
REQ-026 With RESET_SEQ_SW_RESET_EN defined, REQ-016..REQ-019 apply.
REQ-027 Without RESET_SEQ_SW_RESET_EN, SWRST SHALL be unreachable, sw_reset_req SHALL be ignored, sw_reset_ack SHALL be tied 0, and ports SHALL be unchanged.

Verification (SYNC_STAGES=3, STRETCH_CYCLES=16 unless stated)
REQ-028 Power-on: release reset between edges -> auto_out_reset=1 through edge 18, falls after edge 19; seq_state 0->1->2.
REQ-029 SW reset (macro on): pulse sw_reset_req high in RUN until ack -> auto_out_reset high for 16 cycles; sw_reset_ack high for 1 cycle at fall; seq_state 2->3->2.
REQ-030 Abort: assert reset at counter=7 of SWRST -> auto_out_reset=1 and seq_state=0 without a clock edge; no ack; re-release gives 19-edge sequence.
REQ-031 Early request: sw_reset_req held high from reset release -> RUN for one cycle, then SWRST; exactly one ack if req drops on ack.
REQ-032 Boundary: STRETCH_CYCLES=1, SYNC_STAGES=2 -> auto_out_reset falls after edge 3; SWRST lasts 1 cycle with ack.
REQ-033 Macro off: toggle sw_reset_req in RUN -> auto_out_reset stays 0, sw_reset_ack stays 0, seq_state stays 2.
